sqrt_result_bcd_fmt: RTL and testbench

//  Downstream stage of the digit-by-digit square-root engine. Takes its unsigned

---
 rtl/sqrt_result_bcd_fmt.sv | 184 ++++++++++++++++++
 tb/tb_sqrt_result_bcd_fmt.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_bcd_fmt.sv
// sqrt_result_bcd_fmt
// Formats the unsigned fixed-point result of the square-root engine as BCD
// digits for the readout path.
//   - Integer part: iterative double-dabble, one input bit per cycle.
//   - Fraction part: iterative multiply-by-10, one digit per cycle, truncated.
// Valid/ready handshake on both sides, with one conversion in flight.
// Optional build macro: SQRT_BCD_ZERO_BLANK_EN. When it is defined, leading
// zero integer digits are shown as the blank code 4'hF. The units digit is
// never blanked.
module sqrt_result_bcd_fmt #(
  parameter int INT_W       = 8,
  parameter int FRAC_W      = 7,
  parameter int INT_DIGITS  = 3,
  parameter int FRAC_DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INT_W+FRAC_W-1:0]    din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*INT_DIGITS-1:0]    bcd_int,
  output logic [4*FRAC_DIGITS-1:0]   bcd_frac
);

  // Double-dabble register layout is {bcd digits, remaining binary bits}.
  localparam int DD_W  = 4*INT_DIGITS + INT_W;
  localparam int BI_W  = 4*INT_DIGITS;
  localparam int BF_W  = 4*FRAC_DIGITS;
  localparam int P_W   = FRAC_W + 4;
  localparam int CNT_W = $clog2(INT_W + FRAC_DIGITS + 1);

  localparam logic [P_W-1:0]   TEN          = P_W'(10);
  localparam logic [CNT_W-1:0] CNT_INT_LAST  = CNT_W'(INT_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAC_LAST = CNT_W'(FRAC_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INT  = 2'd1,
    S_FRAC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [DD_W-1:0]    r_dd;
  logic [FRAC_W-1:0]  r_frac_acc;
  logic [BF_W-1:0]    r_frac_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BI_W-1:0]    r_bcd_int;
  logic [BF_W-1:0]    r_bcd_frac;

  logic [DD_W-1:0]    w_dd_adj;
  logic [DD_W-1:0]    w_dd_shift;
  logic [P_W-1:0]     w_prod;
  logic [3:0]         w_digit;
  logic [BF_W-1:0]    w_frac_next;
  logic [BI_W-1:0]    w_int_fmt;

  // Replace leading zero integer digits with the blank code, scanning from the
  // most significant digit. Digit 0 (the units digit) is always kept.
  function automatic logic [BI_W-1:0] f_blank_leading(input logic [BI_W-1:0] d);
    logic            lead;
    logic [BI_W-1:0] res;
    res  = d;
    lead = 1'b1;
    for (int i = INT_DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  // Double-dabble step: add 3 to every BCD nibble that is 5 or more, then shift
  // the whole register left by one bit.
  always_comb begin
    w_dd_adj = r_dd;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (r_dd[INT_W + 4*i +: 4] >= 4'd5) begin
        w_dd_adj[INT_W + 4*i +: 4] = r_dd[INT_W + 4*i +: 4] + 4'd3;
      end else begin
        w_dd_adj[INT_W + 4*i +: 4] = r_dd[INT_W + 4*i +: 4];
      end
    end
    w_dd_shift = w_dd_adj << 1;
  end

  // Fraction step: multiply by ten. The carry-out nibble is the next decimal
  // digit, and the low bits are the remainder for the following step.
  always_comb begin
    w_prod      = {4'd0, r_frac_acc} * TEN;
    w_digit     = w_prod[P_W-1:FRAC_W];
    w_frac_next = (r_frac_sh << 4) | {{(BF_W-4){1'b0}}, w_digit};
  end

  // Integer digits as they will be presented, with or without blanking.
  always_comb begin
`ifdef SQRT_BCD_ZERO_BLANK_EN
    w_int_fmt = f_blank_leading(r_dd[DD_W-1:INT_W]);
`else
    w_int_fmt = r_dd[DD_W-1:INT_W];
`endif
  end

  // Conversion FSM. It also owns every datapath register and the registered
  // handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dd        <= {DD_W{1'b0}};
      r_frac_acc  <= {FRAC_W{1'b0}};
      r_frac_sh   <= {BF_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bcd_int   <= {BI_W{1'b0}};
      r_bcd_frac  <= {BF_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dd       <= {{BI_W{1'b0}}, din[INT_W+FRAC_W-1:FRAC_W]};
            r_frac_acc <= din[FRAC_W-1:0];
            r_frac_sh  <= {BF_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= S_INT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_INT: begin
          r_dd <= w_dd_shift;
          if (r_cnt == CNT_INT_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= S_FRAC;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_FRAC: begin
          r_frac_acc <= w_prod[FRAC_W-1:0];
          r_frac_sh  <= w_frac_next;
          if (r_cnt == CNT_FRAC_LAST) begin
            // The results become visible only here, so a partial result is
            // never presented.
            r_cnt       <= {CNT_W{1'b0}};
            r_bcd_int   <= w_int_fmt;
            r_bcd_frac  <= w_frac_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bcd_int   = r_bcd_int;
  assign bcd_frac  = r_bcd_frac;

endmodule

// File: tb/tb_sqrt_result_bcd_fmt.sv
// Directed self-checking bench for sqrt_result_bcd_fmt (default Q8.7 configuration).
module tb_sqrt_result_bcd_fmt;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_int;
  logic [11:0] bcd_frac;

  int n_tests;
  int n_fail;

`ifdef SQRT_BCD_ZERO_BLANK_EN
  localparam logic [11:0] E_INT_0 = 12'hFF0;
  localparam logic [11:0] E_INT_1 = 12'hFF1;
  localparam logic [11:0] E_INT_2 = 12'hFF2;
`else
  localparam logic [11:0] E_INT_0 = 12'h000;
  localparam logic [11:0] E_INT_1 = 12'h001;
  localparam logic [11:0] E_INT_2 = 12'h002;
`endif

  sqrt_result_bcd_fmt dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_int   (bcd_int),
    .bcd_frac  (bcd_frac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one input, measures latency, checks the result, then hands the
  // result back with a one-cycle out_ready pulse.
  task automatic convert(input string tag, input logic [14:0] d,
                         input logic [11:0] ei, input logic [11:0] ef);
    int cyc;
    din      = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, 32'd11);
    check({tag, "_int"}, {20'd0, bcd_int}, {20'd0, ei});
    check({tag, "_frac"}, {20'd0, bcd_frac}, {20'd0, ef});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [14:0] bb_din [3];
  logic [11:0] bb_int [3];
  logic [11:0] bb_frac[3];

  initial begin
    int cyc;
    int got;
    int idx;
    int last;
    logic prev_rdy;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = 15'd0;
    tick();
    tick();
    check("rst_irdy", {31'd0, in_ready}, 32'd1);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_int", {20'd0, bcd_int}, 32'd0);
    check("rst_frac", {20'd0, bcd_frac}, 32'd0);
    reset = 1'b1;
    tick();

    convert("t1", 15'h00B5, E_INT_1, 12'h414);
    convert("t2a", 15'h7FFF, 12'h255, 12'h992);
    convert("t2b", 15'h0100, E_INT_2, 12'h000);
    convert("t3", 15'h0000, E_INT_0, 12'h000);

    // Test 4: hold the result while a second request is presented.
    din = 15'h7FFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 60) begin tick(); cyc++; end
    check("t4_lat", cyc, 32'd11);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin din = 15'h00B5; in_valid = 1'b1; end
      else        begin in_valid = 1'b0; end
      tick();
      check("t4_ov", {31'd0, out_valid}, 32'd1);
      check("t4_irdy", {31'd0, in_ready}, 32'd0);
      check("t4_int", {20'd0, bcd_int}, 32'h255);
      check("t4_frac", {20'd0, bcd_frac}, 32'h992);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_ovdrop", {31'd0, out_valid}, 32'd0);
    check("t4_irdy1", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("t4_noghost", {31'd0, out_valid}, 32'd0);
    check("t4_int_hold", {20'd0, bcd_int}, 32'h255);

    // Test 5: reset in the middle of the integer phase.
    din = 15'h7FFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    check("t5_ov", {31'd0, out_valid}, 32'd0);
    check("t5_irdy", {31'd0, in_ready}, 32'd1);
    check("t5_int", {20'd0, bcd_int}, 32'd0);
    check("t5_frac", {20'd0, bcd_frac}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    convert("t5b", 15'h0040, E_INT_0, 12'h500);

    // Test 6: back-to-back requests with the consumer always ready.
    bb_din[0] = 15'h00B5; bb_int[0] = E_INT_1; bb_frac[0] = 12'h414;
    bb_din[1] = 15'h7FFF; bb_int[1] = 12'h255; bb_frac[1] = 12'h992;
    bb_din[2] = 15'h0040; bb_int[2] = E_INT_0; bb_frac[2] = 12'h500;
    idx = 0; got = 0; cyc = 0; last = 0;
    din = bb_din[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      prev_rdy = in_ready;
      tick();
      cyc++;
      if (prev_rdy && in_valid) begin
        idx++;
        if (idx < 3) din = bb_din[idx];
        else         in_valid = 1'b0;
      end
      if (out_valid) begin
        check("t6_int", {20'd0, bcd_int}, {20'd0, bb_int[got]});
        check("t6_frac", {20'd0, bcd_frac}, {20'd0, bb_frac[got]});
        if (got > 0) check("t6_gap", cyc - last, 32'd13);
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    check("t6_count", got, 32'd3);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("t6_nodup", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
